// File: rtl/m31_vector_loader.sv
// m31_vector_loader
//   Collects a stream of field words (modulus 2^WORD_WIDTH-1) into two
//   operand vectors for a downstream dot-product stage. Words 0..N-1 fill
//   vec1, and words N..2N-1 fill vec2, in arrival order. Once both vectors are
//   complete, the loader holds them stable and refuses input until the
//   consumer acknowledges.
//
// Ports
//   clk         single clock, all state on the rising edge
//   reset       asynchronous active-low reset
//   in_valid    upstream word valid
//   in_data     upstream word
//   in_ready    loader accepts a word this cycle (depends on state only)
//   vec1        first operand vector  [0:VECTOR_SIZE-1]
//   vec2        second operand vector [0:VECTOR_SIZE-1]
//   out_valid   vec1/vec2 complete and stable
//   out_start   one-cycle pulse on the first FULL cycle
//   out_ack     consumer done; releases the buffers
//   fill_count  words accepted in the current load
//
// state  | meaning
// S_FILL | accepting words; in_ready=1, out_valid=0
// S_FULL | both vectors complete; in_ready=0, out_valid=1, waits for out_ack

module m31_vector_loader #(
  parameter int WORD_WIDTH  = 31,
  parameter int VECTOR_SIZE = 16
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              in_valid,
  input  logic [WORD_WIDTH-1:0]             in_data,
  output logic                              in_ready,
  output logic [WORD_WIDTH-1:0]             vec1 [0:VECTOR_SIZE-1],
  output logic [WORD_WIDTH-1:0]             vec2 [0:VECTOR_SIZE-1],
  output logic                              out_valid,
  output logic                              out_start,
  input  logic                              out_ack,
  output logic [$clog2(2*VECTOR_SIZE):0]    fill_count
);

  localparam int CW = $clog2(2*VECTOR_SIZE) + 1;
  localparam int IW = $clog2(VECTOR_SIZE);

  typedef enum logic {S_FILL, S_FULL} state_t;

  state_t                state_q;
  logic [CW-1:0]         fill_count_q;
  logic [CW-1:0]         fill_count_d;
  logic                  in_ready_q;
  logic                  out_valid_q;
  logic                  out_start_q;
  logic [WORD_WIDTH-1:0] vec1_q [0:VECTOR_SIZE-1];
  logic [WORD_WIDTH-1:0] vec2_q [0:VECTOR_SIZE-1];

  logic                  accept;
  logic [WORD_WIDTH-1:0] word_d;
  logic [IW-1:0]         elem_idx;
  logic                  sel_vec2;
  logic                  last_word;

  // in_ready_q mirrors the state, so acceptance never depends combinationally
  // on anything but in_valid and a flop.
  assign accept       = in_valid && in_ready_q;

  // All-ones is the second encoding of zero in this field; store it canonically.
  assign word_d       = (in_data == {WORD_WIDTH{1'b1}}) ? '0 : in_data;

  // Low bits of the count address the element; the next bit picks the vector.
  assign elem_idx     = fill_count_q[IW-1:0];
  assign sel_vec2     = fill_count_q[IW];
  assign last_word    = (fill_count_q == CW'(2*VECTOR_SIZE-1));
  assign fill_count_d = fill_count_q + CW'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_FILL;
      fill_count_q <= '0;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      out_start_q  <= 1'b0;
      for (int k = 0; k < VECTOR_SIZE; k++) begin
        vec1_q[k] <= '0;
        vec2_q[k] <= '0;
      end
    end else begin
      case (state_q)
        S_FILL: begin
          if (accept) begin
            if (sel_vec2) vec2_q[elem_idx] <= word_d;
            else          vec1_q[elem_idx] <= word_d;
            fill_count_q <= fill_count_d;
            if (last_word) begin
              state_q     <= S_FULL;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
              out_start_q <= 1'b1;
            end
          end
        end
        S_FULL: begin
          out_start_q <= 1'b0;
          // An ack may arrive in the out_start cycle itself; FULL then lasts one cycle.
          if (out_ack) begin
            state_q      <= S_FILL;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
            fill_count_q <= '0;
          end
        end
        default: begin
          state_q <= S_FILL;
        end
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_start  = out_start_q;
  assign fill_count = fill_count_q;
  assign vec1       = vec1_q;
  assign vec2       = vec2_q;

endmodule

// File: doc/m31_vector_loader.md
M31_VECTOR_LOADER -- requirements
Module: m31_vector_loader

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 31, element width; field modulus is 2^WORD_WIDTH-1.
REQ-002 SHALL have parameter VECTOR_SIZE, default 16, elements per vector; power of two, >=2.
REQ-003 SHALL have port clk, input, 1, the single clock; all state on rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1, upstream word valid.
REQ-006 SHALL have port in_data, input, WORD_WIDTH, upstream word.
REQ-007 SHALL have port in_ready, output, 1, loader accepts a word this cycle.
REQ-008 SHALL have port vec1, output, VECTOR_SIZE x WORD_WIDTH unpacked [0:VECTOR_SIZE-1], first operand vector.
REQ-009 SHALL have port vec2, output, VECTOR_SIZE x WORD_WIDTH unpacked [0:VECTOR_SIZE-1], second operand vector.
REQ-010 SHALL have port out_valid, output, 1, vec1/vec2 complete and stable.
REQ-011 SHALL have port out_start, output, 1, one-cycle pulse starting the downstream dot-product stage.
REQ-012 SHALL have port out_ack, input, 1, consumer done; releases buffers.
REQ-013 SHALL have port fill_count, output, $clog2(2*VECTOR_SIZE)+1, words accepted in current load.

Function
REQ-014 SHALL implement two states: FILL (in_ready=1, out_valid=0) and FULL (in_ready=0, out_valid=1).
REQ-015 SHALL accept a word exactly on cycles where in_valid && in_ready are both high.
REQ-016 SHALL write accepted word k (k=0..VECTOR_SIZE-1) to vec1[k] and word VECTOR_SIZE+k to vec2[k], strictly in arrival order.
REQ-017 SHALL canonicalise each accepted word: all-ones value (2^WORD_WIDTH-1) stored as 0; all other values stored unchanged.
REQ-018 SHALL increment fill_count by 1 per accepted word in FILL.
REQ-019 SHALL transition FILL->FULL on the clock edge accepting word 2*VECTOR_SIZE-1; out_valid high and in_ready low from the following cycle.
REQ-020 SHALL assert out_start for exactly one cycle, the first cycle of FULL.
REQ-021 SHALL hold vec1, vec2 and fill_count (=2*VECTOR_SIZE) constant throughout FULL.
REQ-022 SHALL transition FULL->FILL on a clock edge where out_ack=1; next cycle in_ready=1, out_valid=0, fill_count=0.
REQ-023 SHALL retain old vector contents after FULL->FILL until overwritten element-by-element.
REQ-024 SHALL ignore out_ack while in FILL.
REQ-025 SHALL ignore in_valid/in_data while in FULL; no word is consumed or lost (in_ready=0).
REQ-026 SHALL accept out_ack in the same cycle as out_start, giving a FULL duration of exactly one cycle.
REQ-027 SHALL not accept input in the cycle out_ack is sampled; earliest next acceptance is the following cycle.
REQ-028 SHALL hold in_valid gaps without state change; in_ready depends only on state (no combinational path from in_valid or out_ack).

Reset
REQ-029 SHALL, on reset low, asynchronously force state FILL, fill_count=0, in_ready=1 after release, out_valid=0, out_start=0, and all vec1/vec2 elements=0.
REQ-030 SHALL discard a partial load when reset is asserted mid-FILL or during FULL; the first word after release goes to vec1[0].
REQ-031 SHALL resume normal operation on the first rising clk edge after reset deasserts.

Verification
REQ-032 SHALL verify back-to-back load: 32 words 1..32 with in_valid constantly high -> vec1[k]=k+1, vec2[k]=k+17; out_valid and out_start rise the cycle after word 32; fill_count=32.
REQ-033 SHALL verify canonicalisation: word 0 = 0x7FFFFFFF, word 1 = 0x7FFFFFFE -> vec1[0]=0, vec1[1]=0x7FFFFFFE.
REQ-034 SHALL verify backpressure: in FULL drive in_valid=1 with 0xAAAA for 5 cycles -> in_ready=0, vectors unchanged; after out_ack, 0xAAAA lands in vec1[0].
REQ-035 SHALL verify immediate ack: out_ack=1 during the out_start cycle -> out_valid high exactly one cycle, in_ready=1 the next cycle, out_start not re-pulsed.
REQ-036 SHALL verify mid-load reset: 10 words accepted, reset low 1 cycle -> all vec elements 0, fill_count=0; the next word is written to vec1[0].
REQ-037 SHALL verify throttled input: in_valid toggling 1/0 for 64 cycles -> FULL after exactly 32 accepted words, order preserved.
